// File: rtl/multi_dataflow_job_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_dataflow_job_sched_if
// Brief    : Request-side and engine-side bundle for the dataflow job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_dataflow_job_sched_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*ADDR_W-1:0] req_in_addr_i;
  logic [N_REQ*ADDR_W-1:0] req_out_addr_i;
  logic                    eng_start_o;
  logic [ADDR_W-1:0]       eng_in_addr_o;
  logic [ADDR_W-1:0]       eng_out_addr_o;
  logic                    eng_done_i;
  logic                    eng_clear_o;
  logic [N_REQ-1:0]        evt_o;
  logic                    busy_o;
  logic [ID_W-1:0]         owner_o;
  logic                    err_o;

  // Scheduler side
  modport slave (
    input  req_valid_i, req_in_addr_i, req_out_addr_i, eng_done_i,
    output req_ready_o, eng_start_o, eng_in_addr_o, eng_out_addr_o,
           eng_clear_o, evt_o, busy_o, owner_o, err_o
  );

  // Requesters plus engine side
  modport master (
    output req_valid_i, req_in_addr_i, req_out_addr_i, eng_done_i,
    input  req_ready_o, eng_start_o, eng_in_addr_o, eng_out_addr_o,
           eng_clear_o, evt_o, busy_o, owner_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/multi_dataflow_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : multi_dataflow_job_sched
// Brief    : Round-robin job scheduler sharing one multi_dataflow engine.
//            Optional watchdog: define MULTI_DATAFLOW_SCHED_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multi_dataflow_job_sched #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input wire logic                  clk_i,
  input wire logic                  rst_ni,
  input wire logic                  clear_i,
  multi_dataflow_job_sched_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_RUN    = 2'd2,
    S_NOTIFY = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  logic [ID_W-1:0]   win;
  logic              any_valid;
  logic [N_REQ-1:0]  ready;
  logic [N_REQ-1:0]  evt;
  logic              start;
  logic              err;
  logic              wdog_hit;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    win = rr_ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[wrap_add(rr_ptr_q, k)]) win = wrap_add(rr_ptr_q, k);
    end
  end

  assign any_valid = |bus.req_valid_i;

`ifdef MULTI_DATAFLOW_SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wdog_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
    end else if (clear_i || state_q != S_RUN) begin
      wdog_cnt_q <= '0;
    end else if (!wdog_hit) begin
      wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
  end

  assign wdog_hit = (state_q == S_RUN) && (wdog_cnt_q == CNT_W'(TIMEOUT_CYC));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign wdog_hit       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    ready      = '0;
    evt        = '0;
    start      = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          ready[win] = 1'b1;
          owner_d    = win;
          in_addr_d  = bus.req_in_addr_i[int'(win)*ADDR_W +: ADDR_W];
          out_addr_d = bus.req_out_addr_i[int'(win)*ADDR_W +: ADDR_W];
          state_d    = S_START;
        end
      end
      S_START: begin
        start   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A done arriving together with the timeout still counts as success
        if (bus.eng_done_i) begin
          state_d = S_NOTIFY;
        end else if (wdog_hit) begin
          err            = 1'b1;
          evt[owner_q]   = 1'b1;
          rr_ptr_d       = wrap_add(owner_q, 1);
          state_d        = S_IDLE;
        end
      end
      S_NOTIFY: begin
        evt[owner_q] = 1'b1;
        rr_ptr_d     = wrap_add(owner_q, 1);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d    = S_IDLE;
      rr_ptr_d   = '0;
      owner_d    = owner_q;
      in_addr_d  = in_addr_q;
      out_addr_d = out_addr_q;
      ready      = '0;
      evt        = '0;
      start      = 1'b0;
      err        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
    end
  end

  // Grant is combinational from IDLE, so it must be masked while in reset
  assign bus.req_ready_o    = rst_ni ? ready : '0;
  assign bus.eng_start_o    = start;
  assign bus.eng_in_addr_o  = in_addr_q;
  assign bus.eng_out_addr_o = out_addr_q;
  assign bus.eng_clear_o    = (clear_i && (state_q != S_IDLE)) || err;
  assign bus.evt_o          = evt;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.owner_o        = owner_q;
  assign bus.err_o          = err;

endmodule
`default_nettype wire

// File: tb/tb_multi_dataflow_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_dataflow_job_sched
// Brief    : Scoreboard bench for the dataflow job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_dataflow_job_sched;
  localparam int N_REQ       = 4;
  localparam int ADDR_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic [31:0] in_a;
    logic [31:0] out_a;
  } job_t;

  job_t        exp_q[$];
  int          model_ptr = 0;
  logic [31:0] in_tab[N_REQ];
  logic [31:0] out_tab[N_REQ];

  multi_dataflow_job_sched_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) bus ();

  multi_dataflow_job_sched #(
    .N_REQ      (N_REQ),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b);
    in_tab[i]  = a;
    out_tab[i] = b;
    bus.req_in_addr_i[i*ADDR_W +: ADDR_W]  = a;
    bus.req_out_addr_i[i*ADDR_W +: ADDR_W] = b;
  endtask

  // Reference round-robin: first valid at or after model_ptr
  task automatic expect_grant(input logic [N_REQ-1:0] v);
    int w;
    job_t j;
    w = -1;
    for (int k = 0; k < N_REQ; k++) begin
      if (w < 0 && v[(model_ptr + k) % N_REQ]) w = (model_ptr + k) % N_REQ;
    end
    if (w >= 0) begin
      j.id = w; j.in_a = in_tab[w]; j.out_a = out_tab[w];
      exp_q.push_back(j);
      model_ptr = (w + 1) % N_REQ;
    end
  endtask

  // Waits for a grant, checks it, and stops in the START cycle
  task automatic start_job(output job_t e, input bit drop);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready_o != '0) break;
      tick();
    end
    chk("grant_wait", 64'(bus.req_ready_o != '0), 64'd1);
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else begin e.id = 0; e.in_a = '0; e.out_a = '0; end
    chk("ready_onehot", 64'(bus.req_ready_o), 64'(1 << e.id));
    tick();
    if (drop) begin
      bus.req_valid_i[e.id] = 1'b0;
      drive_req(e.id, ~e.in_a, ~e.out_a);
    end
    chk("start", 64'(bus.eng_start_o), 64'd1);
    chk("start_ready", 64'(bus.req_ready_o), 64'd0);
    chk("owner", 64'(bus.owner_o), 64'(e.id));
    chk("in_addr", 64'(bus.eng_in_addr_o), 64'(e.in_a));
    chk("out_addr", 64'(bus.eng_out_addr_o), 64'(e.out_a));
  endtask

  // Full job; done arrives done_after cycles after start; ends in NOTIFY
  task automatic do_job(input bit drop, input int done_after, input bit done_in_start);
    job_t e;
    start_job(e, drop);
    if (done_in_start) bus.eng_done_i = 1'b1;
    for (int k = 1; k < done_after; k++) begin
      tick();
      bus.eng_done_i = 1'b0;
      chk("run_busy", 64'(bus.busy_o), 64'd1);
      chk("run_evt", 64'(bus.evt_o), 64'd0);
      chk("run_start", 64'(bus.eng_start_o), 64'd0);
      chk("run_in_addr", 64'(bus.eng_in_addr_o), 64'(e.in_a));
    end
    tick();
    bus.eng_done_i = 1'b1;
    tick();
    bus.eng_done_i = 1'b0;
    chk("notify_evt", 64'(bus.evt_o), 64'(1 << e.id));
    chk("notify_owner", 64'(bus.owner_o), 64'(e.id));
    chk("notify_err", 64'(bus.err_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    job_t e;
    bus.req_valid_i    = '0;
    bus.req_in_addr_i  = '0;
    bus.req_out_addr_i = '0;
    bus.eng_done_i     = 1'b0;

    // Reset with a request already pending
    drive_req(0, 32'h10, 32'h20);
    bus.req_valid_i = 4'b0001;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_start", 64'(bus.eng_start_o), 64'd0);
    chk("rst_evt", 64'(bus.evt_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_eng_clear", 64'(bus.eng_clear_o), 64'd0);
    chk("rst_owner", 64'(bus.owner_o), 64'd0);
    chk("rst_in_addr", 64'(bus.eng_in_addr_o), 64'd0);
    chk("rst_out_addr", 64'(bus.eng_out_addr_o), 64'd0);
    bus.req_valid_i = '0;
    rst_ni = 1'b1;
    tick();

    // Single job on requester 2, addresses scrambled once granted
    drive_req(2, 32'h100, 32'h200);
    bus.req_valid_i = 4'b0100;
    expect_grant(bus.req_valid_i);
    do_job(1'b1, 4, 1'b0);
    tick();
    chk("single_idle_busy", 64'(bus.busy_o), 64'd0);
    chk("single_idle_evt", 64'(bus.evt_o), 64'd0);

    // Clear while idle: pointer back to 0, no engine clear
    clear_i = 1'b1;
    #1;
    chk("clear_idle_eng_clear", 64'(bus.eng_clear_o), 64'd0);
    tick();
    clear_i   = 1'b0;
    model_ptr = 0;

    // Fairness with everyone requesting continuously
    for (int i = 0; i < N_REQ; i++) drive_req(i, 32'h1000 * (i + 1), 32'h8000 + 32'h100 * i);
    bus.req_valid_i = 4'hF;
    repeat (5) expect_grant(4'hF);
    for (int j = 0; j < 5; j++) begin
      do_job(1'b0, 3, 1'b0);
      if (j == 4) bus.req_valid_i = '0;
      tick();
    end

    // Done pulsed during START must be ignored
    bus.req_valid_i = 4'b1000;
    expect_grant(bus.req_valid_i);
    do_job(1'b1, 3, 1'b1);
    tick();

    // Clear during RUN with owner 1
    bus.req_valid_i = 4'b0010;
    expect_grant(bus.req_valid_i);
    start_job(e, 1'b1);
    tick();
    tick();
    clear_i = 1'b1;
    #1;
    chk("clear_run_eng_clear", 64'(bus.eng_clear_o), 64'd1);
    chk("clear_run_evt", 64'(bus.evt_o), 64'd0);
    tick();
    clear_i = 1'b0;
    #1;
    chk("clear_after_eng_clear", 64'(bus.eng_clear_o), 64'd0);
    chk("clear_after_busy", 64'(bus.busy_o), 64'd0);
    chk("clear_after_evt", 64'(bus.evt_o), 64'd0);
    model_ptr = 0;
    bus.req_valid_i = 4'b1001;
    expect_grant(bus.req_valid_i);
    do_job(1'b1, 2, 1'b0);
    bus.req_valid_i = '0;
    tick();

    // Reset in the middle of a job
    bus.req_valid_i = 4'b0100;
    expect_grant(bus.req_valid_i);
    start_job(e, 1'b1);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_mid_evt", 64'(bus.evt_o), 64'd0);
    chk("rst_mid_err", 64'(bus.err_o), 64'd0);
    chk("rst_mid_owner", 64'(bus.owner_o), 64'd0);
    chk("rst_mid_in_addr", 64'(bus.eng_in_addr_o), 64'd0);
    tick();
    rst_ni    = 1'b1;
    model_ptr = 0;
    tick();
    chk("rst_mid_evt_after", 64'(bus.evt_o), 64'd0);

    // Engine never answers
    drive_req(0, 32'hA0, 32'hB0);
    bus.req_valid_i = 4'b0001;
    expect_grant(bus.req_valid_i);
    start_job(e, 1'b1);
`ifdef MULTI_DATAFLOW_SCHED_WATCHDOG_EN
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      tick();
      chk("wd_pre_err", 64'(bus.err_o), 64'd0);
      chk("wd_pre_evt", 64'(bus.evt_o), 64'd0);
    end
    tick();
    chk("wd_err", 64'(bus.err_o), 64'd1);
    chk("wd_eng_clear", 64'(bus.eng_clear_o), 64'd1);
    chk("wd_evt", 64'(bus.evt_o), 64'(1 << e.id));
    tick();
    chk("wd_after_busy", 64'(bus.busy_o), 64'd0);
    chk("wd_after_err", 64'(bus.err_o), 64'd0);
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("nowd_err", 64'(bus.err_o), 64'd0);
      chk("nowd_evt", 64'(bus.evt_o), 64'd0);
      chk("nowd_busy", 64'(bus.busy_o), 64'd1);
    end
    bus.eng_done_i = 1'b1;
    tick();
    bus.eng_done_i = 1'b0;
    chk("nowd_evt_done", 64'(bus.evt_o), 64'(1 << e.id));
    tick();
    chk("nowd_after_busy", 64'(bus.busy_o), 64'd0);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_dataflow_job_sched.md
MULTI_DATAFLOW_JOB_SCHED -- requirements
Module: multi_dataflow_job_sched

Interface
REQ-001 Parameter N_REQ SHALL default to 4: number of requesters sharing the multi_dataflow engine; legal range 2..8.
REQ-002 Parameter ADDR_W SHALL default to 32: width of the input and output stream base addresses.
REQ-003 Parameter TIMEOUT_CYC SHALL default to 65535: watchdog limit in cycles; used only when the watchdog is compiled in (REQ-021).
REQ-004 ID_W SHALL equal $clog2(N_REQ).
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- req_valid_i  in  N_REQ  job request per requester
- req_ready_o  out  N_REQ  job accepted, one-hot
- req_in_addr_i  in  N_REQ*ADDR_W  inStream0 base address per requester
- req_out_addr_i  in  N_REQ*ADDR_W  outStream0 base address per requester
- eng_start_o  out  1  engine FSM start pulse
- eng_in_addr_o  out  ADDR_W  latched inStream0 base address
- eng_out_addr_o  out  ADDR_W  latched outStream0 base address
- eng_done_i  in  1  engine FSM done pulse
- eng_clear_o  out  1  engine abort/clear pulse
- evt_o  out  N_REQ  completion event to the job owner, one-hot
- busy_o  out  1  job in flight
- owner_o  out  ID_W  index of the current job owner
- err_o  out  1  watchdog abort pulse

Function
REQ-006 The FSM SHALL have four states, IDLE, START, RUN and NOTIFY, with the transitions given in REQ-007 to REQ-010.
REQ-007 IDLE: when any req_valid_i bit is set, the block SHALL pick a winner round-robin, starting from rr_ptr and ascending with modulo N_REQ wrap. In the same cycle it SHALL:
- assert req_ready_o[winner] for exactly one cycle;
- register the winner into owner_o;
- register the winner's addresses into eng_in_addr_o and eng_out_addr_o;
- go to START.
REQ-008 START: eng_start_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to RUN; eng_done_i SHALL be ignored in START.
REQ-009 RUN: the FSM SHALL wait for eng_done_i == 1, then go to NOTIFY.
REQ-010 NOTIFY: evt_o[owner_o] SHALL be 1 for one cycle, rr_ptr SHALL become (owner_o+1) mod N_REQ, and the FSM SHALL go to IDLE.
REQ-011 busy_o SHALL be 1 in START, RUN and NOTIFY, and 0 in IDLE.
REQ-012 eng_in_addr_o, eng_out_addr_o and owner_o SHALL stay stable from START through NOTIFY; changes on the request buses during a job SHALL have no effect.
REQ-013 Latency: req_valid_i in IDLE gives req_ready_o in the same cycle and eng_start_o in the next cycle. Minimum job turnaround is 4 cycles (IDLE, START, RUN with done, NOTIFY).
REQ-014 req_ready_o SHALL be 0 in all states other than IDLE; a requester holds req_valid_i and its addresses until it sees ready.
REQ-015 Simultaneous requests: exactly one grant per IDLE visit. A requester that keeps valid asserted SHALL be served within N_REQ jobs.
REQ-016 A requester that drops req_valid_i before it is granted SHALL lose nothing: no grant and no event.
REQ-017 clear_i SHALL be synchronous and have priority over all other behaviour. It SHALL:
- return the FSM to IDLE;
- set rr_ptr to 0;
- force all pulse outputs to 0;
- assert eng_clear_o for one cycle if busy_o was 1.

Reset
REQ-018 While rst_ni == 0, the FSM SHALL be IDLE, rr_ptr 0, and owner_o, eng_in_addr_o, eng_out_addr_o 0.
REQ-019 While rst_ni == 0, req_ready_o, eng_start_o, eng_clear_o, evt_o, busy_o and err_o SHALL all be 0.
REQ-020 Reset mid-job SHALL abandon the job silently: no evt_o and no err_o; the engine is reset by the same rst_ni.

Configuration
REQ-021 With macro MULTI_DATAFLOW_SCHED_WATCHDOG_EN defined, the block SHALL include the watchdog:
- a counter clears on entry to RUN and increments each cycle in RUN;
- if the counter reaches TIMEOUT_CYC before eng_done_i, the block SHALL pulse eng_clear_o and err_o for one cycle, pulse evt_o[owner_o], update rr_ptr as in NOTIFY, and go to IDLE;
- if eng_done_i arrives in the same cycle as the timeout, done wins and there is no error.
REQ-022 Without the macro, the counter SHALL not exist, err_o SHALL be tied to 0, and eng_clear_o SHALL be driven only by clear_i (REQ-017).

Verification
REQ-023 Single job: requester 2 valid with in=0x100, out=0x200 → ready[2] at cycle t, start at t+1 with addresses 0x100/0x200, done at t+5 → evt_o[2] at t+6, busy_o 0 at t+7.
REQ-024 Fairness: all four valid continuously, done 3 cycles after each start → grant order 0,1,2,3,0; no requester served twice before all others are served once.
REQ-025 Done in START: eng_done_i pulsed in the START cycle → ignored; FSM stays in RUN until a later done.
REQ-026 Clear mid-RUN: clear_i asserted while the owner is 1 → eng_clear_o pulses once, no evt_o, next grant searches from 0.
REQ-027 Watchdog (macro on, TIMEOUT_CYC=16): no done → err_o and eng_clear_o pulse 16 cycles after RUN entry and evt_o[owner] fires. Macro off → waits indefinitely with err_o 0.
REQ-028 Address stability: req_in_addr_i of the owner changes during RUN → eng_in_addr_o unchanged until the next grant.
